// File: rtl/trig_pkg.sv
// Shared types and constants for the trigger pattern detector.
// Contents: FSM state enum, config register offsets, channel/stage limits.
package trig_pkg;

    localparam int unsigned MAX_CH     = 8;
    localparam int unsigned MAX_STAGES = 4;
    localparam int unsigned CFG_W      = 8;
    localparam int unsigned STAGE_W    = 2;
    localparam int unsigned CNT_W      = 8;

    // Per-stage config register offsets (cfg_addr[1:0])
    localparam logic [1:0] REG_LVL  = 2'd0;
    localparam logic [1:0] REG_VAL  = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;
    localparam logic [1:0] REG_CNT  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        WAIT   = 3'd2,
        FIRE   = 3'd3,
        DONE   = 3'd4
    } trig_state_e;

endpackage

// File: rtl/trig_stage_match.sv
// One sequence stage: its config registers and the combinational level/edge
// match on the sampled probe history.
// Optional feature macro: TRIG_COUNT_EN (adds the occurrence-count register).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cfg_we/addr/data    config write port shared by all stages
//   d1, d2              current and previous probe samples
//   cnt_cfg             occurrence count register (TRIG_COUNT_EN only)
//   match_c             combinational stage match
module trig_stage_match
    import trig_pkg::*;
#(
    parameter int unsigned CH        = 8,
    parameter int unsigned STAGE_IDX = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_addr,
    input  logic [CFG_W-1:0]    cfg_data,
    input  logic [CH-1:0]       d1,
    input  logic [CH-1:0]       d2,
`ifdef TRIG_COUNT_EN
    output logic [CNT_W-1:0]    cnt_cfg,
`endif
    output logic                match_c
);

    logic [CH-1:0] lvl_mask_q, lvl_mask_d;
    logic [CH-1:0] value_q, value_d;
    logic [CH-1:0] edge_mask_q, edge_mask_d;
`ifdef TRIG_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic          sel_c;
    logic [CH-1:0] edge_hit_c;
    logic          lvl_ok_c;
    logic          edge_ok_c;

    assign sel_c = cfg_we && (cfg_addr[3:2] == STAGE_W'(STAGE_IDX));

    // Register write decode
    always_comb begin
        lvl_mask_d  = lvl_mask_q;
        value_d     = value_q;
        edge_mask_d = edge_mask_q;
`ifdef TRIG_COUNT_EN
        cnt_d       = cnt_q;
`endif
        if (sel_c) begin
            case (cfg_addr[1:0])
                REG_LVL:  lvl_mask_d  = cfg_data[CH-1:0];
                REG_VAL:  value_d     = cfg_data[CH-1:0];
                REG_EDGE: edge_mask_d = cfg_data[CH-1:0];
                default: begin
`ifdef TRIG_COUNT_EN
                    cnt_d = cfg_data;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_mask_q  <= '0;
            value_q     <= '0;
            edge_mask_q <= '0;
`ifdef TRIG_COUNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            lvl_mask_q  <= lvl_mask_d;
            value_q     <= value_d;
            edge_mask_q <= edge_mask_d;
`ifdef TRIG_COUNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // value bit picks the edge direction: 1 = rising, 0 = falling
    assign edge_hit_c = (value_q & d1 & ~d2) | (~value_q & ~d1 & d2);
    assign lvl_ok_c   = ((d1 ^ value_q) & lvl_mask_q) == '0;
    assign edge_ok_c  = (edge_mask_q == '0) || ((edge_mask_q & edge_hit_c) != '0);
    assign match_c    = lvl_ok_c && edge_ok_c;

`ifdef TRIG_COUNT_EN
    assign cnt_cfg = cnt_q;
`endif

endmodule

// File: rtl/trig_pattern_detect.sv
// Trigger source for the capture path: samples the probes, runs an armed
// multi-stage level/edge sequence and emits a one-cycle trig_out pulse.
// Optional feature macro: TRIG_COUNT_EN (per-stage occurrence counting).
// Ports:
//   CLK, nRST   clock, synchronous active-low reset
//   Din         probe channels (already synchronous)
//   ENTrig      arm level; 0 aborts to IDLE
//   cfg_we/addr/data  config write, addr = {stage, reg}
//   trig_out    one-cycle trigger pulse (registered)
//   armed       searching (SETTLE/WAIT), registered
//   stage       stage being searched, 0 outside WAIT, registered
module trig_pattern_detect
    import trig_pkg::*;
#(
    parameter int unsigned CH     = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [CH-1:0]    Din,
    input  logic             ENTrig,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             trig_out,
    output logic             armed,
    output logic [1:0]       stage
);

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES - 1);

    logic [CH-1:0]        d1_q, d2_q;
    trig_state_e          state_q, state_d;
    logic [STAGE_W-1:0]   stage_idx_q, stage_idx_d;
    logic                 settle_q, settle_d;
    logic                 trig_q, trig_d;
    logic                 armed_q, armed_d;
    logic [STAGE_W-1:0]   stage_out_q, stage_out_d;
`ifdef TRIG_COUNT_EN
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]     cnt_cfg_c [MAX_STAGES];
`endif

    logic [MAX_STAGES-1:0] match_vec_c;
    logic                  match_c;
    logic                  adv_c;

    // Stage instances; absent stages never match and never accept writes
    for (genvar g = 0; g < MAX_STAGES; g++) begin : g_stage
        if (g < STAGES) begin : g_on
            trig_stage_match #(
                .CH        (CH),
                .STAGE_IDX (g)
            ) u_stage (
                .clk      (CLK),
                .rst_n    (nRST),
                .cfg_we   (cfg_we),
                .cfg_addr (cfg_addr),
                .cfg_data (cfg_data),
                .d1       (d1_q),
                .d2       (d2_q),
`ifdef TRIG_COUNT_EN
                .cnt_cfg  (cnt_cfg_c[g]),
`endif
                .match_c  (match_vec_c[g])
            );
        end else begin : g_off
            assign match_vec_c[g] = 1'b0;
`ifdef TRIG_COUNT_EN
            assign cnt_cfg_c[g] = '0;
`endif
        end
    end

    assign match_c = match_vec_c[stage_idx_q];

    // Advance on the first match, or on the (count+1)-th with counting enabled
`ifdef TRIG_COUNT_EN
    assign adv_c = match_c && (hit_cnt_q == cnt_cfg_c[stage_idx_q]);
`else
    assign adv_c = match_c;
`endif

    // Next state and registered-output decode
    always_comb begin
        state_d     = state_q;
        stage_idx_d = stage_idx_q;
        settle_d    = settle_q;
`ifdef TRIG_COUNT_EN
        hit_cnt_d   = hit_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (ENTrig) begin
                    state_d  = SETTLE;
                    settle_d = 1'b0;
                end
            end
            SETTLE: begin
                // Two cycles let d1/d2 fill with live samples
                if (settle_q) begin
                    state_d     = WAIT;
                    stage_idx_d = '0;
`ifdef TRIG_COUNT_EN
                    hit_cnt_d   = '0;
`endif
                end else begin
                    settle_d = 1'b1;
                end
            end
            WAIT: begin
                if (adv_c) begin
`ifdef TRIG_COUNT_EN
                    hit_cnt_d = '0;
`endif
                    if (stage_idx_q == LAST_STAGE) begin
                        state_d = FIRE;
                    end else begin
                        stage_idx_d = stage_idx_q + STAGE_W'(1);
                    end
                end
`ifdef TRIG_COUNT_EN
                else if (match_c) begin
                    hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end
`endif
            end
            FIRE:    state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Disarm overrides everything, including a pending FIRE
        if (!ENTrig) begin
            state_d     = IDLE;
            stage_idx_d = '0;
            settle_d    = 1'b0;
`ifdef TRIG_COUNT_EN
            hit_cnt_d   = '0;
`endif
        end

        trig_d      = (state_d == FIRE);
        armed_d     = (state_d == SETTLE) || (state_d == WAIT);
        stage_out_d = (state_d == WAIT) ? stage_idx_d : '0;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            d1_q        <= '0;
            d2_q        <= '0;
            state_q     <= IDLE;
            stage_idx_q <= '0;
            settle_q    <= 1'b0;
            trig_q      <= 1'b0;
            armed_q     <= 1'b0;
            stage_out_q <= '0;
`ifdef TRIG_COUNT_EN
            hit_cnt_q   <= '0;
`endif
        end else begin
            d1_q        <= Din;
            d2_q        <= d1_q;
            state_q     <= state_d;
            stage_idx_q <= stage_idx_d;
            settle_q    <= settle_d;
            trig_q      <= trig_d;
            armed_q     <= armed_d;
            stage_out_q <= stage_out_d;
`ifdef TRIG_COUNT_EN
            hit_cnt_q   <= hit_cnt_d;
`endif
        end
    end

    assign trig_out = trig_q;
    assign armed    = armed_q;
    assign stage    = stage_out_q;

endmodule

// File: tb/tb_trig_pattern_detect.sv
// Self-checking bench for trig_pattern_detect (CH=8, STAGES=2).
// Honours TRIG_COUNT_EN when defined.
module tb_trig_pattern_detect;

    localparam int unsigned CH  = 8;
    localparam int unsigned STG = 2;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [7:0] Din = '0;
    logic       ENTrig = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       trig_out;
    logic       armed;
    logic [1:0] stage;

    trig_pattern_detect #(.CH(CH), .STAGES(STG)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .Din      (Din),
        .ENTrig   (ENTrig),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .trig_out (trig_out),
        .armed    (armed),
        .stage    (stage)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int cyc    = 0;

    // ---------------- behavioural reference ----------------
    localparam int P_IDLE = 0, P_SETTLE = 1, P_WAIT = 2, P_FIRE = 3, P_DONE = 4;
    logic [7:0] m_lvl [4];
    logic [7:0] m_val [4];
    logic [7:0] m_edge[4];
    logic [7:0] m_cnt [4];
    logic [7:0] m_d1, m_d2;
    int m_phase = P_IDLE;
    int m_settle = 0;
    int m_stage = 0;
    int m_hits = 0;
    int m_ws;
    bit m_hit;

    function automatic bit model_match(int k);
        bit lvl = 1'b1;
        bit any_edge = 1'b0;
        bit edge_en = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (m_lvl[k][b] && (m_d1[b] != m_val[k][b])) lvl = 1'b0;
            if (m_edge[k][b]) begin
                edge_en = 1'b1;
                if (m_val[k][b] ? (m_d1[b] && !m_d2[b]) : (!m_d1[b] && m_d2[b]))
                    any_edge = 1'b1;
            end
        end
        return lvl && (!edge_en || any_edge);
    endfunction

    function automatic int needed(int k);
`ifdef TRIG_COUNT_EN
        return int'(m_cnt[k]) + 1;
`else
        return (k >= 0) ? 1 : 1;
`endif
    endfunction

    always @(posedge CLK) begin
        if (!nRST) begin
            for (int k = 0; k < 4; k++) begin
                m_lvl[k] = '0; m_val[k] = '0; m_edge[k] = '0; m_cnt[k] = '0;
            end
            m_d1 = '0; m_d2 = '0;
            m_phase = P_IDLE; m_settle = 0; m_stage = 0; m_hits = 0;
        end else begin
            m_hit = (m_phase == P_WAIT) && model_match(m_stage);
            case (m_phase)
                P_IDLE: if (ENTrig) begin m_phase = P_SETTLE; m_settle = 2; end
                P_SETTLE: begin
                    m_settle = m_settle - 1;
                    if (m_settle == 0) begin m_phase = P_WAIT; m_stage = 0; m_hits = 0; end
                end
                P_WAIT: if (m_hit) begin
                    m_hits = m_hits + 1;
                    if (m_hits >= needed(m_stage)) begin
                        m_hits = 0;
                        if (m_stage == int'(STG) - 1) m_phase = P_FIRE;
                        else m_stage = m_stage + 1;
                    end
                end
                P_FIRE: m_phase = P_DONE;
                default: ;
            endcase
            if (!ENTrig) begin m_phase = P_IDLE; m_stage = 0; m_hits = 0; end
            m_d2 = m_d1;
            m_d1 = Din;
            m_ws = int'(cfg_addr[3:2]);
            if (cfg_we && m_ws < int'(STG)) begin
                case (cfg_addr[1:0])
                    2'd0: m_lvl[m_ws]  = cfg_data;
                    2'd1: m_val[m_ws]  = cfg_data;
                    2'd2: m_edge[m_ws] = cfg_data;
                    default: begin
`ifdef TRIG_COUNT_EN
                        m_cnt[m_ws] = cfg_data;
`endif
                    end
                endcase
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (trig_out === 1'b1) pulses++;
        check("model_trig",  int'(trig_out), (m_phase == P_FIRE) ? 1 : 0);
        check("model_armed", int'(armed), (m_phase == P_SETTLE || m_phase == P_WAIT) ? 1 : 0);
        check("model_stage", int'(stage), (m_phase == P_WAIT) ? m_stage : 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0; ENTrig = 1'b0; Din = '0;
        tick();
        nRST = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_n;
        logic       en;
        logic [7:0] din;
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
        logic       e_trig;
        logic       e_armed;
        logic [1:0] e_stage;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic e, logic [7:0] d, logic w, logic [3:0] a,
                                logic [7:0] cd, logic et, logic ea, logic [1:0] es);
        vec_t v;
        v.rst_n = r; v.en = e; v.din = d; v.we = w; v.addr = a; v.data = cd;
        v.e_trig = et; v.e_armed = ea; v.e_stage = es;
        return v;
    endfunction

    int pbase;
    int r;

    initial begin
        // Single-level trigger on bit 0; stage 1 left at all-zero (always matches)
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'd0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 4'h0, 8'h01, 0, 0, 2'd0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 4'h1, 8'h01, 0, 0, 2'd0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 4'hC, 8'hFF, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 8'h00, 0, 4'h0, 8'h00, 0, 1, 2'd0));
        tbl.push_back(mk(1, 1, 8'h00, 0, 4'h0, 8'h00, 0, 1, 2'd0));
        tbl.push_back(mk(1, 1, 8'h00, 0, 4'h0, 8'h00, 0, 1, 2'd0));
        tbl.push_back(mk(1, 1, 8'h00, 0, 4'h0, 8'h00, 0, 1, 2'd0));
        tbl.push_back(mk(1, 1, 8'h01, 0, 4'h0, 8'h00, 0, 1, 2'd0));
        tbl.push_back(mk(1, 1, 8'h01, 0, 4'h0, 8'h00, 0, 1, 2'd1));
        tbl.push_back(mk(1, 1, 8'h01, 0, 4'h0, 8'h00, 1, 0, 2'd0));
        tbl.push_back(mk(1, 1, 8'h01, 0, 4'h0, 8'h00, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 8'h01, 0, 4'h0, 8'h00, 0, 0, 2'd0));
        tbl.push_back(mk(1, 0, 8'h01, 0, 4'h0, 8'h00, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 8'h01, 0, 4'h0, 8'h00, 0, 1, 2'd0));
        // All-zero config: fire 2+STAGES edges after the arming edge
        tbl.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 8'h00, 0, 4'h0, 8'h00, 0, 1, 2'd0));
        tbl.push_back(mk(1, 1, 8'h00, 0, 4'h0, 8'h00, 0, 1, 2'd0));
        tbl.push_back(mk(1, 1, 8'h00, 0, 4'h0, 8'h00, 0, 1, 2'd0));
        tbl.push_back(mk(1, 1, 8'h00, 0, 4'h0, 8'h00, 0, 1, 2'd1));
        tbl.push_back(mk(1, 1, 8'h00, 0, 4'h0, 8'h00, 1, 0, 2'd0));
        tbl.push_back(mk(1, 1, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'd0));

        foreach (tbl[i]) begin
            nRST = tbl[i].rst_n; ENTrig = tbl[i].en; Din = tbl[i].din;
            cfg_we = tbl[i].we; cfg_addr = tbl[i].addr; cfg_data = tbl[i].data;
            tick();
            check("tbl_trig",  int'(trig_out), int'(tbl[i].e_trig));
            check("tbl_armed", int'(armed),    int'(tbl[i].e_armed));
            check("tbl_stage", int'(stage),    int'(tbl[i].e_stage));
        end
        cfg_we = 1'b0;

        // Falling edge on bit 7 fires; rising edge does not
        do_reset();
        cfg_write(4'h2, 8'h80);
        cfg_write(4'h1, 8'h00);
        Din = 8'h80; ENTrig = 1'b1; pbase = pulses;
        ticks(6);
        check("fall_no_early", pulses - pbase, 0);
        Din = 8'h00;
        ticks(5);
        check("fall_fires", pulses - pbase, 1);
        ENTrig = 1'b0; tick();
        ENTrig = 1'b1; ticks(4); pbase = pulses;
        Din = 8'h80;
        ticks(6);
        check("rise_no_fire", pulses - pbase, 0);

        // Two-stage sequence: reverse order, then correct order
        do_reset();
        cfg_write(4'h0, 8'hFF);
        cfg_write(4'h1, 8'h0A);
        cfg_write(4'h6, 8'h10);
        cfg_write(4'h5, 8'h10);
        Din = 8'h00; ENTrig = 1'b1; ticks(3);
        pbase = pulses;
        Din = 8'h10; ticks(3);
        Din = 8'h00; ticks(2);
        check("rev_stage", int'(stage), 0);
        check("rev_no_fire", pulses - pbase, 0);
        Din = 8'h0A; ticks(2);
        check("seq_stage1", int'(stage), 1);
        Din = 8'h1A; tick();
        check("seq_not_yet", int'(trig_out), 0);
        tick();
        check("seq_fire", int'(trig_out), 1);
        tick();
        check("seq_one_cycle", int'(trig_out), 0);
        check("seq_pulses", pulses - pbase, 1);

        // Abort at stage 1 by disarm, re-arm settle, abort by reset
        ENTrig = 1'b0; tick();
        Din = 8'h00; ENTrig = 1'b1; ticks(3);
        Din = 8'h0A; ticks(2);
        check("abort_at_stage1", int'(stage), 1);
        pbase = pulses;
        ENTrig = 1'b0; Din = 8'h1A; tick();
        check("disarm_armed", int'(armed), 0);
        check("disarm_stage", int'(stage), 0);
        ticks(3);
        check("disarm_no_pulse", pulses - pbase, 0);
        Din = 8'h0A; ticks(2);
        ENTrig = 1'b1; tick();
        check("rearm_settle1", int'(armed), 1);
        tick();
        check("rearm_settle2_stage", int'(stage), 0);
        tick();
        check("rearm_wait_stage0", int'(stage), 0);
        tick();
        check("rearm_stage1", int'(stage), 1);
        nRST = 1'b0; Din = 8'h1A; tick();
        check("rst_armed", int'(armed), 0);
        check("rst_stage", int'(stage), 0);
        nRST = 1'b1; ticks(4);
        check("rst_no_pulse", pulses - pbase, 0);

`ifdef TRIG_COUNT_EN
        // Stage 0 needs four rising edges on bit 0
        do_reset();
        cfg_write(4'h2, 8'h01);
        cfg_write(4'h1, 8'h01);
        cfg_write(4'h3, 8'h03);
        Din = 8'h00; ENTrig = 1'b1; ticks(3);
        pbase = pulses;
        for (int p = 0; p < 3; p++) begin
            Din = 8'h01; tick();
            Din = 8'h00; tick();
        end
        ticks(3);
        check("cnt_no_fire_3", pulses - pbase, 0);
        Din = 8'h01; tick();
        Din = 8'h00; ticks(4);
        check("cnt_fire_4", pulses - pbase, 1);
`endif

        // Randomised traffic against the reference
        do_reset();
        ENTrig = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            nRST = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) ENTrig = ~ENTrig;
            r = $urandom_range(0, 7);
            if (r == 0) Din = 8'($urandom);
            else if (r < 3) Din = Din ^ 8'(1 << $urandom_range(0, 7));
            cfg_we   = ($urandom_range(0, 24) == 0);
            cfg_addr = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       cfg_data = 8'h00;
                1:       cfg_data = 8'(1 << $urandom_range(0, 7));
                2:       cfg_data = 8'($urandom_range(0, 3));
                default: cfg_data = 8'($urandom);
            endcase
            tick();
        end
        cfg_we = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
